pkt_meta_dropper: RTL

// - Sits directly downstream of the channel FIFO stage. It consumes that stage's out_pkt and out_meta streams.
// - For each packet it pairs one metadata word with the packet's flits. It then forwards or discards the whole packet,

---
 rtl/pkt_meta_dropper_pkg.sv | 15 +
 rtl/pkt_meta_dropper_pkt_out_reg.sv | 44 ++++
 rtl/pkt_meta_dropper.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pkt_meta_dropper_pkg.sv
// Shared types and default widths for the packet/metadata dropper.
package pkt_meta_dropper_pkg;

  localparam int PKT_DATA_W   = 512;
  localparam int PKT_EMPTY_W  = 6;
  localparam int PKT_META_W   = 128;
  localparam int PKT_DROP_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } dropper_state_t;

endpackage

// File: rtl/pkt_meta_dropper_pkt_out_reg.sv
// One-deep valid/ready pipeline register carrying {sop, eop, data, empty}.
// Accepts a new flit whenever it is empty or being drained this cycle.
module pkt_out_reg #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic               in_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  input  logic               out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // Load a new flit, hold while stalled, drop valid after a handshake with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
      out_data  <= in_data;
      out_empty <= in_empty;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_meta_dropper.sv
// Pairs one metadata word with each packet and forwards or discards the packet
// according to the metadata drop bit. Keeps per-outcome statistics.
import pkt_meta_dropper_pkg::*;

module pkt_meta_dropper #(
  parameter int DATA_W   = PKT_DATA_W,
  parameter int EMPTY_W  = PKT_EMPTY_W,
  parameter int META_W   = PKT_META_W,
  parameter int DROP_BIT = PKT_DROP_BIT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic [DATA_W-1:0]  in_pkt_data,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  input  logic               in_pkt_valid,
  output logic               in_pkt_ready,
  input  logic [META_W-1:0]  in_meta_data,
  input  logic               in_meta_valid,
  output logic               in_meta_ready,
  output logic               out_pkt_sop,
  output logic               out_pkt_eop,
  output logic [DATA_W-1:0]  out_pkt_data,
  output logic [EMPTY_W-1:0] out_pkt_empty,
  output logic               out_pkt_valid,
  output logic [META_W-1:0]  out_pkt_meta,
  input  logic               out_pkt_ready,
  output logic [31:0]        stats_fwd_pkt,
  output logic [31:0]        stats_drop_pkt,
  output logic [31:0]        stats_drop_flit,
  output logic [31:0]        stats_err
);

  dropper_state_t     state_q, state_d;
  logic [META_W-1:0]  meta_q;
  logic               first_q;
  logic               reg_ready;
  logic               accept;
  logic               fwd_load;
  logic               drop_acc;

  // Meta pop is gated by reset so nothing is popped while reset is held.
  assign in_meta_ready = ~Rst & (state_q == IDLE) & in_meta_valid;
  assign accept        = in_pkt_valid & in_pkt_ready;
  assign fwd_load      = accept & (state_q == FWD);
  assign drop_acc      = accept & (state_q == DROP);

  // Flit acceptance depends on state: stalled in IDLE, throttled by the output register in FWD.
  always_comb begin
    in_pkt_ready = 1'b0;
    case (state_q)
      FWD:     in_pkt_ready = reg_ready;
      DROP:    in_pkt_ready = 1'b1;
      default: in_pkt_ready = 1'b0;
    endcase
  end

  // Next-state: meta selects FWD/DROP, an accepted eop returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_meta_ready) state_d = in_meta_data[DROP_BIT] ? DROP : FWD;
      FWD:  if (accept & in_pkt_eop) state_d = IDLE;
      DROP: if (accept & in_pkt_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched metadata and first-flit tracking for the sop error check.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      meta_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_meta_ready) begin
        meta_q  <= in_meta_data;
        first_q <= 1'b1;
      end else if (accept) begin
        first_q <= 1'b0;
      end
    end
  end

  // Sideband meta follows each loaded flit, so it only changes at the next packet's first flit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) out_pkt_meta <= '0;
    else if (fwd_load) out_pkt_meta <= meta_q;
  end

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stats_fwd_pkt   <= '0;
      stats_drop_pkt  <= '0;
      stats_drop_flit <= '0;
      stats_err       <= '0;
    end else begin
      if (out_pkt_valid & out_pkt_ready & out_pkt_eop) stats_fwd_pkt <= stats_fwd_pkt + 32'd1;
      if (drop_acc) stats_drop_flit <= stats_drop_flit + 32'd1;
      if (drop_acc & in_pkt_eop) stats_drop_pkt <= stats_drop_pkt + 32'd1;
      if (accept & in_pkt_sop & ~first_q) stats_err <= stats_err + 32'd1;
    end
  end

  pkt_out_reg #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_out_reg (
    .clk       (Clk),
    .rst       (Rst),
    .load      (fwd_load),
    .in_sop    (in_pkt_sop),
    .in_eop    (in_pkt_eop),
    .in_data   (in_pkt_data),
    .in_empty  (in_pkt_empty),
    .in_ready  (reg_ready),
    .out_sop   (out_pkt_sop),
    .out_eop   (out_pkt_eop),
    .out_data  (out_pkt_data),
    .out_empty (out_pkt_empty),
    .out_valid (out_pkt_valid),
    .out_ready (out_pkt_ready)
  );

endmodule
